timer_entry: RTL and testbench

//  Keypad-side writer for the microwave countdown chain: collects BCD key presses into an MM:SS buffer.
//  On start it issues a one-cycle active-low load with the buffered digits, then gates count enable with the 1 Hz tick.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/bcd_shift_buffer.sv | 44 ++++
 rtl/timer_entry.sv | 139 +++++++++++++
 tb/tb_timer_entry.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer: controller state encoding,
// BCD digit geometry and the default seconds-tens limit.
package microwave_pkg;

    localparam int DIGIT_W          = 4;
    localparam int BCD_MAX          = 9;
    localparam int SEC_TENS_MAX_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A key code is a usable digit only when it is a legal BCD value.
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] code);
        return code <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_shift_buffer.sv
// Keypad digit buffer: new digits enter at the least significant position,
// older digits move up one place and the most significant digit falls off.
module bcd_shift_buffer
    import microwave_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          shift,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          clear,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          nonzero
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] digit_reg;
            logic [DIGIT_W-1:0] shift_src;

            if (gi == 0) begin : g_first
                assign shift_src = digit_in;
            end else begin : g_rest
                assign shift_src = digits[(gi-1)*DIGIT_W +: DIGIT_W];
            end

            // Each digit either clears, takes its lower neighbour on a shift, or holds.
            always_ff @(posedge clk) begin
                if (clr || clear) begin
                    digit_reg <= '0;
                end else if (shift) begin
                    digit_reg <= shift_src;
                end
            end

            assign digits[gi*DIGIT_W +: DIGIT_W] = digit_reg;
        end
    endgenerate

    assign nonzero = |digits;

endmodule

// File: rtl/timer_entry.sv
// Keypad-side controller for the countdown chain: buffers MM:SS key entry,
// pulses an active-low load on start, gates the 1 Hz tick while running,
// reports completion from the chain's zero flag and clears the chain on cancel.
// Optional feature macro: TIMER_SEC_CLAMP_EN (limit seconds to 59 at load).
module timer_entry
    import microwave_pkg::*;
#(
    parameter int NUM_DIGITS = 4
`ifdef TIMER_SEC_CLAMP_EN
    ,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_digit,
    input  logic                          key_clear,
    input  logic                          key_start,
    input  logic                          tick,
    input  logic                          timer_zero,
    output logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    output logic                          loadn,
    output logic                          clrn_out,
    output logic                          count_en,
    output logic [DIGIT_W*NUM_DIGITS-1:0] entry_digits,
    output logic                          running,
    output logic                          done
);

    localparam int BUF_W = DIGIT_W * NUM_DIGITS;

    state_t             state_reg;
    state_t             state_next;
    logic               run_first_reg;
    logic               loadn_reg;
    logic               clrn_reg;
    logic               done_reg;
    logic [BUF_W-1:0]   load_data_reg;
    logic [BUF_W-1:0]   load_value;
    logic [BUF_W-1:0]   buf_digits;
    logic               buf_nonzero;
    logic               buf_shift;
    logic               buf_clear;

    bcd_shift_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buffer (
        .clk      (clk),
        .clr      (clr),
        .shift    (buf_shift),
        .digit_in (key_digit),
        .clear    (buf_clear),
        .digits   (buf_digits),
        .nonzero  (buf_nonzero)
    );

`ifdef TIMER_SEC_CLAMP_EN
    // Out-of-range seconds become the largest legal value (e.g. 0:99 -> 0:59).
    always_comb begin
        load_value = buf_digits;
        if (buf_digits[2*DIGIT_W-1:DIGIT_W] > DIGIT_W'(SEC_TENS_MAX)) begin
            load_value[2*DIGIT_W-1:DIGIT_W] = DIGIT_W'(SEC_TENS_MAX);
            load_value[DIGIT_W-1:0]         = DIGIT_W'(BCD_MAX);
        end
    end
`else
    assign load_value = buf_digits;
`endif

    // Next-state and buffer control; clear beats start beats digit entry.
    always_comb begin
        state_next = state_reg;
        buf_shift  = 1'b0;
        buf_clear  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ENTRY: begin
                if (key_clear) begin
                    buf_clear  = 1'b1;
                    state_next = ST_IDLE;
                end else if (key_start) begin
                    state_next = buf_nonzero ? ST_LOAD : ST_IDLE;
                end else if (key_valid && is_bcd(key_digit)) begin
                    buf_shift  = 1'b1;
                    state_next = ST_ENTRY;
                end
            end
            ST_LOAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                // The chain may still show zero on the cycle right after its load.
                if (key_clear) begin
                    buf_clear  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timer_zero && !run_first_reg) begin
                    buf_clear  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered, glitch-free pulses and held load value.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= ST_IDLE;
            run_first_reg <= 1'b0;
            loadn_reg     <= 1'b1;
            clrn_reg      <= 1'b1;
            done_reg      <= 1'b0;
            load_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            run_first_reg <= (state_reg == ST_LOAD);
            loadn_reg     <= (state_next != ST_LOAD);
            clrn_reg      <= !((state_reg == ST_RUN) && key_clear);
            done_reg      <= (state_next == ST_DONE);
            if (state_next == ST_LOAD) begin
                load_data_reg <= load_value;
            end
        end
    end

    assign load_data    = load_data_reg;
    assign loadn        = loadn_reg;
    assign clrn_out     = clrn_reg;
    assign done         = done_reg;
    assign entry_digits = buf_digits;
    assign running      = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
    assign count_en     = tick && (state_reg == ST_RUN);

endmodule

// File: tb/tb_timer_entry.sv
// Self-checking bench for timer_entry: directed key sequences, a behavioural
// model of the keypad/timer rules compared every cycle, and literal spot checks.
module tb_timer_entry;

    logic        clk;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic        key_start;
    logic        tick;
    logic        timer_zero;
    logic [15:0] load_data;
    logic        loadn;
    logic        clrn_out;
    logic        count_en;
    logic [15:0] entry_digits;
    logic        running;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    timer_entry dut (
        .clk          (clk),
        .clr          (clr),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_clear    (key_clear),
        .key_start    (key_start),
        .tick         (tick),
        .timer_zero   (timer_zero),
        .load_data    (load_data),
        .loadn        (loadn),
        .clrn_out     (clrn_out),
        .count_en     (count_en),
        .entry_digits (entry_digits),
        .running      (running),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The buffer is held as a decimal number (0..9999); phases are plain ints.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_DONE = 4;

    int m_mode = M_IDLE;
    int m_val  = 0;     // typed-in time as a decimal number
    int m_load = 0;     // value presented to the chain
    int m_age  = 0;     // completed RUN cycles
    bit m_clrp = 0;     // clear pulse visible this cycle

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_secs(input int v);
`ifdef TIMER_SEC_CLAMP_EN
        int secs;
        secs = v % 100;
        if (secs / 10 > 5) return v - secs + 59;
        return v;
`else
        return v;
`endif
    endfunction

    task automatic model_step();
        m_clrp = 0;
        if (clr) begin
            m_mode = M_IDLE;
            m_val  = 0;
            m_load = 0;
            m_age  = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_ENTRY: begin
                    if (key_clear) begin
                        m_val  = 0;
                        m_mode = M_IDLE;
                    end else if (key_start) begin
                        if (m_val != 0) begin
                            m_mode = M_LOAD;
                            m_load = clamp_secs(m_val);
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end else if (key_valid && int'(key_digit) <= 9) begin
                        m_val  = (m_val * 10 + int'(key_digit)) % 10000;
                        m_mode = M_ENTRY;
                    end
                end
                M_LOAD: begin
                    m_mode = M_RUN;
                    m_age  = 0;
                end
                M_RUN: begin
                    if (key_clear) begin
                        m_clrp = 1;
                        m_val  = 0;
                        m_mode = M_IDLE;
                    end else if (timer_zero && m_age > 0) begin
                        m_val  = 0;
                        m_mode = M_DONE;
                    end else begin
                        m_age++;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("entry_digits", entry_digits, to_bcd(m_val));
            check("load_data", load_data, to_bcd(m_load));
            check("loadn", 16'(loadn), 16'(m_mode != M_LOAD));
            check("clrn_out", 16'(clrn_out), 16'(!m_clrp));
            check("done", 16'(done), 16'(m_mode == M_DONE));
            check("running", 16'(running), 16'(m_mode == M_LOAD || m_mode == M_RUN));
            check("count_en", 16'(count_en), 16'(m_mode == M_RUN && tick));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_start();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        cyc();
        key_clear = 1'b0;
    endtask

    logic [3:0] mix_keys [10] = '{4'd7, 4'hF, 4'd0, 4'd4, 4'hA, 4'd2, 4'd8, 4'd1, 4'hB, 4'd6};

    initial begin
        clr        = 1'b1;
        key_valid  = 1'b0;
        key_digit  = 4'd0;
        key_clear  = 1'b0;
        key_start  = 1'b0;
        tick       = 1'b0;
        timer_zero = 1'b0;
        cyc();
        chk_en = 1;
        cyc();
        clr = 1'b0;
        check("rst_entry", entry_digits, 16'h0000);
        check("rst_load_data", load_data, 16'h0000);
        check("rst_loadn", 16'(loadn), 16'h1);
        check("rst_running", 16'(running), 16'h0);
        $display("txn reset: entry=%h loadn=%b running=%b", entry_digits, loadn, running);

        // Keys 1,3,0 then start; run with a tick; timer_zero on third RUN cycle.
        key(4'd1); key(4'd3); key(4'd0);
        check("entry_130", entry_digits, 16'h0130);
        press_start();
        check("load_0130", load_data, 16'h0130);
        check("loadn_low", 16'(loadn), 16'h0);
        check("running_load", 16'(running), 16'h1);
        $display("txn start 1:30: loadn=%b load_data=%h", loadn, load_data);
        cyc();
        tick = 1'b1;
        #1;
        check("count_en_tick", 16'(count_en), 16'h1);
        cyc();
        tick = 1'b0;
        #1;
        check("count_en_notick", 16'(count_en), 16'h0);
        cyc();
        timer_zero = 1'b1;
        cyc();
        timer_zero = 1'b0;
        tick = 1'b1;
        #1;
        check("done_pulse", 16'(done), 16'h1);
        check("count_en_done", 16'(count_en), 16'h0);
        tick = 1'b0;
        cyc();
        check("done_cleared", 16'(done), 16'h0);
        check("idle_running", 16'(running), 16'h0);
        $display("txn countdown complete: done pulse seen, running=%b", running);

        // Overflow drop and an ignored key code.
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("entry_2345", entry_digits, 16'h2345);
        key(4'hC);
        check("entry_ignore_C", entry_digits, 16'h2345);
        $display("txn entry overflow: entry=%h", entry_digits);
        key_valid = 1'b1; key_digit = 4'd7; key_clear = 1'b1;
        cyc();
        key_valid = 1'b0; key_clear = 1'b0;
        check("clear_beats_digit", entry_digits, 16'h0000);
        $display("txn clear+digit: entry=%h", entry_digits);

        // Start with nothing entered, then with only zeros entered.
        press_start();
        check("empty_start_loadn", 16'(loadn), 16'h1);
        check("empty_start_running", 16'(running), 16'h0);
        key(4'd0); key(4'd0);
        press_start();
        check("zero_start_loadn", 16'(loadn), 16'h1);
        $display("txn empty start: loadn=%b running=%b", loadn, running);

        // 9,9 start; timer_zero held from the first RUN cycle, then clear with it.
        key(4'd9); key(4'd9);
        press_start();
`ifdef TIMER_SEC_CLAMP_EN
        check("load_99_clamped", load_data, 16'h0059);
`else
        check("load_99_raw", load_data, 16'h0099);
`endif
        check("entry_99_raw", entry_digits, 16'h0099);
        timer_zero = 1'b1;
        cyc();
        cyc();
        check("first_zero_ignored", 16'(running), 16'h1);
        key_clear = 1'b1;
        cyc();
        key_clear = 1'b0;
        timer_zero = 1'b0;
        check("clrn_low", 16'(clrn_out), 16'h0);
        check("no_done_on_clear", 16'(done), 16'h0);
        check("clear_idle", 16'(running), 16'h0);
        cyc();
        check("clrn_high", 16'(clrn_out), 16'h1);
        $display("txn 0:99 run cancelled: load_data=%h", load_data);

        // Reset in the middle of a run.
        key(4'd5);
        press_start();
        cyc(); cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("midrun_load_data", load_data, 16'h0000);
        check("midrun_entry", entry_digits, 16'h0000);
        check("midrun_running", 16'(running), 16'h0);
        check("midrun_loadn", 16'(loadn), 16'h1);
        $display("txn reset mid-run: running=%b load_data=%h", running, load_data);

        // Mixed key table, then a full run, model-checked every cycle.
        for (int i = 0; i < 10; i++) begin
            key(mix_keys[i]);
            $display("txn key %h: entry=%h", mix_keys[i], entry_digits);
        end
        press_start();
        for (int i = 0; i < 6; i++) begin
            tick = i[0];
            timer_zero = (i == 4);
            cyc();
        end
        tick = 1'b0;
        timer_zero = 1'b0;
        cyc(); cyc();
        $display("txn mixed run: running=%b entry=%h", running, entry_digits);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
